// File: rtl/oserdes_lane_tx.sv
// Multi-lane parallel-to-serial transmitter: LSB-first SDR/DDR slots, training
// pattern insertion and sticky underrun detection at word boundaries.
module oserdes_lane_tx #(
    parameter int               LANES         = 2,
    parameter int               WIDTH         = 8,
    parameter int               DDR           = 1,
    parameter int               IDLE_TRISTATE = 1,
    parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'h5C)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   train_en,
    output logic [LANES-1:0]       o_rise,
    output logic [LANES-1:0]       o_fall,
    output logic [LANES-1:0]       tq,
    output logic                   underrun
);
    localparam int BPC   = (DDR != 0) ? 2 : 1;
    localparam int SLOTS = WIDTH / BPC;
    localparam int SW    = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [SW-1:0]    LAST    = SW'(SLOTS - 1);
    localparam logic [LANES-1:0] TQ_IDLE = (IDLE_TRISTATE != 0) ? {LANES{1'b1}} : {LANES{1'b0}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_TRAIN} state_t;

    state_t                 state_q, state_d;
    logic [SW-1:0]          slot_q, slot_d;
    logic [LANES*WIDTH-1:0] word_q, word_d;
    logic [LANES*WIDTH-1:0] src;
    logic [LANES-1:0]       rise_q, rise_d, fall_q, fall_d, tq_q, tq_d;
    logic                   underrun_q, underrun_d;
    logic                   boundary, accept;

    // A word boundary is any idle cycle or the last slot of a word/pattern.
    assign boundary = (state_q == S_IDLE) || (slot_q == LAST);
    assign in_ready = !rst && !train_en && boundary;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        word_d     = word_q;
        underrun_d = underrun_q;
        if (!boundary) begin
            slot_d = slot_q + 1'b1;
        end else if (train_en) begin
            state_d = S_TRAIN;
            slot_d  = '0;
        end else if (accept) begin
            state_d = S_RUN;
            slot_d  = '0;
            word_d  = in_data;
        end else begin
            state_d = S_IDLE;
            slot_d  = '0;
            if (state_q == S_RUN) underrun_d = 1'b1;
        end
    end

    // Output bits are decoded from the next state so they leave flops aligned with the slot.
    assign src  = (state_d == S_TRAIN) ? {LANES{TRAIN_PATTERN}} : word_d;
    assign tq_d = (state_d == S_IDLE) ? TQ_IDLE : '0;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign rise_d[k] = (state_d == S_IDLE) ? 1'b0 : src[k*WIDTH + BPC*int'(slot_d)];
        if (DDR != 0) begin : g_ddr
            assign fall_d[k] = (state_d == S_IDLE) ? 1'b0 : src[k*WIDTH + 2*int'(slot_d) + 1];
        end else begin : g_sdr
            assign fall_d[k] = rise_d[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            word_q     <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            tq_q       <= TQ_IDLE;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            word_q     <= word_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            tq_q       <= tq_d;
            underrun_q <= underrun_d;
        end
    end

    assign o_rise   = rise_q;
    assign o_fall   = fall_q;
    assign tq       = tq_q;
    assign underrun = underrun_q;
endmodule

// File: tb/tb_oserdes_lane_tx.sv
// Bench for oserdes_lane_tx: queue-of-slots reference model for a 2x8 DDR
// instance, plus a directed check of a 1x4 SDR instance.
module tb_oserdes_lane_tx;
    logic        clk = 1'b0;
    logic        rst, in_valid, train_en, in_ready, underrun;
    logic [15:0] in_data;
    logic [1:0]  o_rise, o_fall, tq;

    logic        s_rst, s_valid, s_train, s_ready, s_underrun;
    logic [3:0]  s_data;
    logic [0:0]  s_rise, s_fall, s_tq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    oserdes_lane_tx dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .train_en(train_en), .o_rise(o_rise), .o_fall(o_fall), .tq(tq), .underrun(underrun)
    );

    oserdes_lane_tx #(.LANES(1), .WIDTH(4), .DDR(0)) dut_sdr (
        .clk(clk), .rst(s_rst), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
        .train_en(s_train), .o_rise(s_rise), .o_fall(s_fall), .tq(s_tq), .underrun(s_underrun)
    );

    // Reference model: every accepted word or pattern becomes 4 queued output slots.
    localparam int K_IDLE = 0, K_DATA = 1, K_TRAIN = 2;
    typedef struct packed {
        logic [1:0] r;
        logic [1:0] f;
        logic [1:0] t;
        logic [1:0] kind;
    } ent_t;
    localparam ent_t IDLE_E = '{r: 2'b00, f: 2'b00, t: 2'b11, kind: 2'd0};

    ent_t q[$];
    ent_t cur = IDLE_E;
    logic exp_urun = 1'b0;
    logic last_rdy;

    function automatic void push_word(input logic [15:0] w, input int kind);
        ent_t e;
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 2; k++) begin
                e.r[k] = w[k*8 + 2*s];
                e.f[k] = w[k*8 + 2*s + 1];
            end
            e.t    = 2'b00;
            e.kind = 2'(kind);
            q.push_back(e);
        end
    endfunction

    task automatic step(input string tag);
        logic exp_rdy;
        #1;
        exp_rdy = !rst && !train_en && (q.size() == 0);
        last_rdy = in_ready;
        n_tests++;
        if (in_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL %s in_ready got %b expected %b", tag, in_ready, exp_rdy);
        end
        if (rst) begin
            q.delete();
            cur = IDLE_E;
            exp_urun = 1'b0;
        end else begin
            if (q.size() == 0) begin
                if (train_en) push_word({2{8'h5C}}, K_TRAIN);
                else if (in_valid) push_word(in_data, K_DATA);
                else if (cur.kind == 2'(K_DATA)) exp_urun = 1'b1;
            end
            if (q.size() > 0) cur = q.pop_front();
            else cur = IDLE_E;
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({o_rise, o_fall, tq, underrun} !== {cur.r, cur.f, cur.t, exp_urun}) begin
            n_fail++;
            $display("FAIL %s outs rise/fall/tq/urun got %b/%b/%b/%b expected %b/%b/%b/%b",
                     tag, o_rise, o_fall, tq, underrun, cur.r, cur.f, cur.t, exp_urun);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step("reset");
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; train_en = 1'b0; in_data = 16'hFFFF;
        step("rst_a");
        step("rst_b");
        n_tests++;
        if (tq !== 2'b11 || o_rise !== 2'b00 || underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state tq/rise/urun got %b/%b/%b expected 11/00/0", tq, o_rise, underrun);
        end
        rst = 1'b0; in_valid = 1'b0;
        step("rst_rel");
    endtask

    task automatic test_known_word();
        logic [1:0] kr[4];
        logic [1:0] kf[4];
        kr = '{2'b11, 2'b11, 2'b00, 2'b00};
        kf = '{2'b10, 2'b10, 2'b01, 2'b01};
        in_data = 16'h0FA5; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
            end
            step("known");
            n_tests++;
            if (o_rise !== kr[i] || o_fall !== kf[i] || tq !== 2'b00) begin
                n_fail++;
                $display("FAIL known_slot%0d rise/fall/tq got %b/%b/%b expected %b/%b/00",
                         i, o_rise, o_fall, tq, kr[i], kf[i]);
            end
        end
        step("underrun");
        for (int i = 0; i < 3; i++) step("idle_hold");
        n_tests++;
        if (underrun !== 1'b1 || tq !== 2'b11 || o_rise !== 2'b00 || o_fall !== 2'b00) begin
            n_fail++;
            $display("FAIL underrun_sticky urun/tq got %b/%b expected 1/11", underrun, tq);
        end
        do_reset();
        step("post_rst");
        n_tests++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_clear got %b expected 0", underrun);
        end
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 16'($urandom);
            step("b2b");
            n_tests++;
            if (last_rdy !== (i % 4 == 0)) begin
                n_fail++;
                $display("FAIL b2b_accept_%0d in_ready got %b expected %b", i, last_rdy, (i % 4 == 0));
            end
        end
        n_tests++;
        if (underrun !== 1'b0 || tq !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_stream urun/tq got %b/%b expected 0/00", underrun, tq);
        end
        in_valid = 1'b0;
        step("b2b_end");
        do_reset();
    endtask

    task automatic test_train();
        in_valid = 1'b1; in_data = 16'($urandom);
        step("tr_acc");
        in_valid = 1'b0;
        step("tr_slot1");
        train_en = 1'b1;
        for (int i = 0; i < 11; i++) step("tr_on");
        train_en = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_data = 16'($urandom);
            step("tr_exit");
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) step("tr_drain");
        do_reset();
    endtask

    task automatic test_reset_midword();
        logic [15:0] w;
        in_valid = 1'b1; in_data = 16'($urandom);
        step("mw_acc");
        in_valid = 1'b0;
        step("mw_s1");
        step("mw_s2");
        rst = 1'b1;
        step("mw_rst");
        n_tests++;
        if (tq !== 2'b11 || o_rise !== 2'b00 || o_fall !== 2'b00) begin
            n_fail++;
            $display("FAIL midword_rst tq/rise/fall got %b/%b/%b expected 11/00/00", tq, o_rise, o_fall);
        end
        rst = 1'b0; in_valid = 1'b1;
        w = 16'($urandom); in_data = w;
        step("mw_new");
        n_tests++;
        if (o_rise !== {w[8], w[0]} || o_fall !== {w[9], w[1]}) begin
            n_fail++;
            $display("FAIL midword_new rise/fall got %b/%b expected %b/%b",
                     o_rise, o_fall, {w[8], w[0]}, {w[9], w[1]});
        end
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) step("mw_drain");
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 9) == 0) train_en = ~train_en;
            in_data  = 16'($urandom);
            step("random");
        end
        rst = 1'b0; in_valid = 1'b0; train_en = 1'b0;
        for (int i = 0; i < 5; i++) step("rnd_drain");
        do_reset();
    endtask

    task automatic test_sdr();
        logic [3:0] exp_bits;
        exp_bits = 4'b1001;
        s_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        s_rst = 1'b0; s_data = 4'h9; s_valid = 1'b1;
        #1;
        n_tests++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sdr_ready got %b expected 1", s_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); @(negedge clk);
            s_valid = 1'b0; s_data = 4'h6;
            n_tests++;
            if (s_rise[0] !== exp_bits[i] || s_fall[0] !== exp_bits[i] || s_tq !== 1'b0) begin
                n_fail++;
                $display("FAIL sdr_slot%0d rise/fall/tq got %b/%b/%b expected %b/%b/0",
                         i, s_rise, s_fall, s_tq, exp_bits[i], exp_bits[i]);
            end
        end
        @(posedge clk); @(negedge clk);
        n_tests++;
        if (s_tq !== 1'b1 || s_rise !== 1'b0 || s_underrun !== 1'b1) begin
            n_fail++;
            $display("FAIL sdr_idle tq/rise/urun got %b/%b/%b expected 1/0/1", s_tq, s_rise, s_underrun);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; train_en = 1'b0; in_data = '0;
        s_rst = 1'b1; s_valid = 1'b0; s_train = 1'b0; s_data = '0;
        test_reset();
        test_known_word();
        test_back_to_back();
        test_train();
        test_reset_midword();
        test_random();
        test_sdr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
